// File: rtl/audio_voice_mixer.sv
// Time-multiplexed signed voice mixer: one MAC per cycle, master gain, range limit.
// Define MIXER_SATURATION_EN to clamp the output (and report clip_o); otherwise it wraps.
module audio_voice_mixer #(
  parameter int CHANNELS     = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sample_valid_i,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] channel_sample_i,
  input  logic [CHANNELS*GAIN_WIDTH-1:0]   channel_gain_i,
  input  logic [CHANNELS-1:0]              channel_enable_i,
  input  logic [GAIN_WIDTH-1:0]            master_gain_i,
  output logic                             busy_o,
  output logic [SAMPLE_WIDTH-1:0]          mixed_sample_o,
  output logic                             mixed_valid_o,
  output logic                             clip_o,
  output logic                             frame_drop_o
);

  // state      | meaning
  // IDLE       | waiting for a frame strobe
  // ACCUMULATE | one channel product added per cycle
  // SCALE      | master gain and range limit, result registered
  // OUTPUT     | mixed_valid_o high, then back to IDLE

  localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW  = SAMPLE_WIDTH + $clog2(CHANNELS) + 1;
  localparam int PW  = SAMPLE_WIDTH + GAIN_WIDTH;
  localparam int SW2 = AW + GAIN_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, ACCUMULATE, SCALE, OUTPUT} state_t;

  state_t                         state;
  logic [IW-1:0]                  idx;
  logic signed [AW-1:0]           acc;
  logic signed [SAMPLE_WIDTH-1:0] snap_sample [CHANNELS];
  logic signed [GAIN_WIDTH-1:0]   snap_gain   [CHANNELS];
  logic [CHANNELS-1:0]            snap_en;
  logic signed [GAIN_WIDTH-1:0]   snap_master;

  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           prod_sh;
  logic signed [AW-1:0]           term;
  logic signed [SW2-1:0]          scaled;
  logic signed [SW2-1:0]          scaled_sh;
  logic [SAMPLE_WIDTH-1:0]        result;
  logic                           clip_next;

  always_comb begin
    prod      = snap_sample[idx] * snap_gain[idx];
    prod_sh   = prod >>> (GAIN_WIDTH - 1);
    term      = snap_en[idx] ? AW'(prod_sh) : '0;
    scaled    = acc * snap_master;
    scaled_sh = scaled >>> (GAIN_WIDTH - 1);
    result    = '0;
    clip_next = 1'b0;
`ifdef MIXER_SATURATION_EN
    // In range only if every bit from the output sign bit upward agrees.
    if ((&scaled_sh[SW2-1:SAMPLE_WIDTH-1]) || !(|scaled_sh[SW2-1:SAMPLE_WIDTH-1])) begin
      result = scaled_sh[SAMPLE_WIDTH-1:0];
    end else begin
      clip_next = 1'b1;
      result    = scaled_sh[SW2-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    end
`else
    result = SAMPLE_WIDTH'(scaled_sh);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      acc            <= '0;
      snap_en        <= '0;
      snap_master    <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        snap_sample[ch] <= '0;
        snap_gain[ch]   <= '0;
      end
      busy_o         <= 1'b0;
      mixed_sample_o <= '0;
      mixed_valid_o  <= 1'b0;
      clip_o         <= 1'b0;
      frame_drop_o   <= 1'b0;
    end else begin
      frame_drop_o  <= sample_valid_i && (state != IDLE);
      mixed_valid_o <= 1'b0;
      clip_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid_i) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
              snap_sample[ch] <= channel_sample_i[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH];
              snap_gain[ch]   <= channel_gain_i[ch*GAIN_WIDTH +: GAIN_WIDTH];
            end
            snap_en     <= channel_enable_i;
            snap_master <= master_gain_i;
            acc         <= '0;
            idx         <= '0;
            busy_o      <= 1'b1;
            state       <= ACCUMULATE;
          end
        end
        ACCUMULATE: begin
          acc <= acc + term;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= SCALE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCALE: begin
          mixed_sample_o <= result;
          mixed_valid_o  <= 1'b1;
          clip_o         <= clip_next;
          state          <= OUTPUT;
        end
        OUTPUT: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_voice_mixer.md
# audio_voice_mixer

Parametrised, time-multiplexed mixer for the APU audio synthesis path. It mixes an arbitrary number of signed voice channels into one sample stream. On each frame strobe it snapshots all channel samples and gains, then multiplies-and-accumulates one channel per cycle with a single multiplier. It applies a master gain, range-limits the result and presents one mixed sample with a valid pulse. It replaces the fixed four-wave mixing stage with a CHANNELS-wide mixer that can sit after any set of generators and envelope modulators.

## Interface
- CHANNELS, 8: number of voice channels, ≥2.
- SAMPLE_WIDTH, 16: signed two's-complement sample width, input and output.
- GAIN_WIDTH, 16: signed gain width, format Q1.(GAIN_WIDTH-1).

- clk_i  in  1  system clock, all logic rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- sample_valid_i  in  1  frame strobe; accepted only in IDLE.
- channel_sample_i  in  CHANNELS×SAMPLE_WIDTH  signed per-channel samples.
- channel_gain_i  in  CHANNELS×GAIN_WIDTH  signed per-channel gains.
- channel_enable_i  in  CHANNELS  per-channel enable.
- master_gain_i  in  GAIN_WIDTH  signed master gain.
- busy_o  out  1  high when the FSM is not in IDLE.
- mixed_sample_o  out  SAMPLE_WIDTH  mixed sample; holds its value between frames.
- mixed_valid_o  out  1  one-cycle pulse when mixed_sample_o updates.
- clip_o  out  1  pulses with mixed_valid_o when the result was clamped.
- frame_drop_o  out  1  one-cycle pulse; a strobe arrived while busy.

## Operation
- States: IDLE, ACCUMULATE, SCALE, OUTPUT.
- **IDLE:** on sample_valid_i, register all samples, gains, enables and master gain into snapshot registers. Clear the accumulator, set channel index to 0 and go to ACCUMULATE. Later input changes do not affect the frame.
- **ACCUMULATE:** each cycle, add the product for channel idx to the accumulator.
  - Product is (sample × gain) >>> (GAIN_WIDTH-1): arithmetic shift, floor rounding.
  - A disabled channel adds 0.
  - idx increments each cycle. After idx = CHANNELS-1, go to SCALE.
- Accumulator width is SAMPLE_WIDTH+$clog2(CHANNELS)+1 and can never overflow.
- **SCALE:** compute (accumulator × master) >>> (GAIN_WIDTH-1) at full width, then range-limit to SAMPLE_WIDTH (see Configuration). Go to OUTPUT.
- **OUTPUT:** register the result to mixed_sample_o, assert mixed_valid_o, and assert clip_o if clamped. Return to IDLE.
- A sample_valid_i in any state other than IDLE is ignored. frame_drop_o pulses in the next cycle and the frame in flight is unaffected.
- Gain 0x8000 (GAIN_WIDTH=16) means -1.0. (-2^(SW-1)) × (-1.0) is handled by the range-limit stage.

## Timing
- Cycle 0 is the cycle in which sample_valid_i is sampled high in IDLE.
- ACCUMULATE occupies cycles 1..CHANNELS, SCALE is cycle CHANNELS+1, OUTPUT is cycle CHANNELS+2.
- mixed_valid_o is high in cycle CHANNELS+2 only. Latency is CHANNELS+2 cycles.
- busy_o is high in cycles 1..CHANNELS+2.
- A new strobe is accepted from cycle CHANNELS+3, so the minimum frame spacing is CHANNELS+3 cycles.
- Reset values: mixed_sample_o=0, mixed_valid_o=0, clip_o=0, frame_drop_o=0, busy_o=0. FSM goes to IDLE; accumulator, index and snapshot registers clear to 0.
- Reset asserted mid-frame aborts the frame: no mixed_valid_o, and mixed_sample_o returns to 0.
- A strobe in the same cycle that reset deasserts is ignored.

## Configuration
- MIXER_SATURATION_EN defined: the SCALE result is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1], and clip_o reports clamping.
- MIXER_SATURATION_EN undefined: the low SAMPLE_WIDTH bits are taken (two's-complement wrap), and clip_o is tied to 0.

## Test plan
All scenarios use CHANNELS=4, SAMPLE_WIDTH=16, GAIN_WIDTH=16.
- **Basic mix:** samples 1000/2000/3000/4000, all enabled, gains 0x4000, master 0x4000, strobe at cycle 0 -> mixed_sample_o=2500; mixed_valid_o only at cycle 6; busy_o high in cycles 1..6.
- **Clamp or wrap:** all samples 0x7FFF, gains 0x7FFF, master 0x7FFF -> with macro: 0x7FFF and clip_o=1; without macro: 0xFFF4 and clip_o=0.
- **Sign handling:** ch0=-2000 (0xF830), gain 0x4000, others disabled, master 0x8000 -> 1000 (0x03E8).
- **Snapshot isolation:** ch1 enabled with sample 500 and gain 0x7FFF, others disabled, master 0x7FFF. Change all inputs to 0 at cycle 1 -> 498.
- **Busy drop:** strobes at cycles 0 and 3 -> frame_drop_o at cycle 4; exactly one mixed_valid_o, at cycle 6, carrying the cycle-0 frame. A strobe at cycle 7 is accepted.
- **Reset mid-frame:** rst_i pulsed at cycle 3 after a non-zero prior output -> no mixed_valid_o; mixed_sample_o=0 and busy_o=0 during reset. The next strobe completes normally.
